// File: rtl/tt_um_sub_serial.sv
// rtl/tt_um_sub_serial.sv - bit-serial A-B subtractor, LSB first, one bit per clock
module tt_um_sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] ui_in,
  input  logic [7:0]       uio_in,
  output logic [WIDTH-1:0] uo_out,
  output logic [7:0]       uio_out,
  output logic [7:0]       uio_oe
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             busy, done, borrow, zero;

  logic             load_a, load_b, start;
  logic             a0, b0, diff, br_next;
  logic [WIDTH-1:0] res_next;
  logic             unused_inputs;

  assign load_a = uio_in[0];
  assign load_b = uio_in[1];
  assign start  = uio_in[2];
  assign unused_inputs = ^{ena, uio_in[7:3]};

  // One full-subtractor stage; the difference bit enters at the result MSB.
  assign a0       = a_sh[0];
  assign b0       = b_sh[0];
  assign diff     = a0 ^ b0 ^ br;
  assign br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
  assign res_next = {diff, res_sh[WIDTH-1:1]};

  assign uio_out = {zero, borrow, done, busy, 4'b0000};
  assign uio_oe  = 8'hF0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      uo_out <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_a) a_reg <= ui_in;
          if (load_b) b_reg <= ui_in;
          // Shift registers take the pre-edge A/B, so a same-edge load waits for the next operation.
          if (start) begin
            a_sh   <= a_reg;
            b_sh   <= b_reg;
            res_sh <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          br     <= br_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            uo_out <= res_next;
            borrow <= br_next;
            zero   <= (res_next == '0);
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_sub_serial.sv
// tb/tb_tt_um_sub_serial.sv - table-driven, scoreboarded bench for tt_um_sub_serial
module tb_tt_um_sub_serial;

  logic       clk, rst, ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  tt_um_sub_serial #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       borrow;
    logic       zero;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       borrow;
    logic       zero;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_fail   = 0;

  wire busy = uio_out[4];
  wire done = uio_out[5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Results are compared whenever the DUT raises done.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", uo_out, e.res);
        check("borrow", uio_out[6], e.borrow);
        check("zero", uio_out[7], e.zero);
        check("uio_low", uio_out[3:0], 4'h0);
      end
    end
  end

  task automatic push_exp(input logic [7:0] res, input logic borrow, input logic zero);
    exp_t e;
    e.res = res;
    e.borrow = borrow;
    e.zero = zero;
    sb.push_back(e);
  endtask

  // Called just after a negedge; holds data/ctrl across one posedge.
  task automatic pulse(input logic [7:0] data, input logic [7:0] ctrl);
    ui_in  = data;
    uio_in = ctrl;
    @(negedge clk);
    uio_in = 8'h00;
  endtask

  task automatic wait_done(input int exp_busy);
    int n = 0;
    int guard = 0;
    while (!done && guard < 40) begin
      if (busy) n++;
      @(negedge clk);
      guard++;
    end
    check("done_seen", done, 1);
    check("busy_cycles", n, exp_busy);
    @(negedge clk);
    check("done_single", done, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic run_vec(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] res, input logic borrow, input logic zero);
    pulse(a, 8'h01);
    pulse(b, 8'h02);
    push_exp(res, borrow, zero);
    pulse(8'h00, 8'h04);
    wait_done(8);
    check("hold_result", uo_out, res);
  endtask

  initial begin
    vecs[0]  = '{8'h50, 8'h26, 8'h2A, 1'b0, 1'b0};
    vecs[1]  = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[2]  = '{8'h7F, 8'h7F, 8'h00, 1'b0, 1'b1};
    vecs[3]  = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[4]  = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[5]  = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0};
    vecs[6]  = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b0};
    vecs[7]  = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[8]  = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1};
    vecs[9]  = '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b0};
    vecs[10] = '{8'hC3, 8'h3C, 8'h87, 1'b0, 1'b0};
    vecs[11] = '{8'h3C, 8'hC3, 8'h79, 1'b1, 1'b0};

    rst = 1'b1;
    ena = 1'b1;
    ui_in = 8'h00;
    uio_in = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'hF0);

    // Loads on the first edge after release must be honoured.
    rst = 1'b0;
    pulse(8'h50, 8'h03);
    check("zero_after_rst", uio_out[7], 0);
    push_exp(8'h00, 1'b0, 1'b1);
    pulse(8'h00, 8'h04);
    wait_done(8);

    for (int i = 0; i < 12; i++)
      run_vec(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].borrow, vecs[i].zero);

    for (int i = 0; i < 4; i++) begin
      logic [7:0] ra, rb, d;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      d  = ra - rb;
      run_vec(ra, rb, d, ra < rb, d == 8'h00);
    end

    // Load/start during RUN are dropped; A register must keep 0x10.
    pulse(8'h10, 8'h01);
    pulse(8'h01, 8'h02);
    push_exp(8'h0F, 1'b0, 1'b0);
    pulse(8'h00, 8'h04);
    @(negedge clk);
    @(negedge clk);
    pulse(8'h99, 8'h05);
    wait_done(5);
    repeat (3) @(negedge clk);
    check("no_queued_start", busy, 0);
    push_exp(8'h0F, 1'b0, 1'b0);
    pulse(8'h00, 8'h04);
    wait_done(8);

    // Same-edge load_a and start: start uses the old A.
    pulse(8'h30, 8'h01);
    pulse(8'h10, 8'h02);
    push_exp(8'h20, 1'b0, 1'b0);
    pulse(8'h05, 8'h05);
    wait_done(8);
    push_exp(8'hF5, 1'b1, 1'b0);
    pulse(8'h00, 8'h04);
    wait_done(8);

    // Reset mid-RUN clears outputs at once and suppresses done.
    pulse(8'h50, 8'h01);
    pulse(8'h26, 8'h02);
    pulse(8'h00, 8'h04);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_uo_out", uo_out, 8'h00);
    check("async_rst_uio_out", uio_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    begin
      int dones = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (done) dones++;
      end
      check("no_done_after_abort", dones, 0);
    end
    check("zero_after_abort", uio_out[7], 0);
    run_vec(8'h50, 8'h26, 8'h2A, 1'b0, 1'b0);

    // Start held high: an operation every WIDTH+2 cycles.
    pulse(8'h09, 8'h01);
    pulse(8'h0C, 8'h02);
    repeat (3) push_exp(8'hFD, 1'b1, 1'b0);
    uio_in = 8'h04;
    begin
      int dones = 0;
      int first = -1;
      int last = -1;
      for (int i = 1; i <= 30; i++) begin
        @(negedge clk);
        if (done) begin
          dones++;
          if (first < 0) first = i;
          last = i;
        end
      end
      uio_in = 8'h00;
      check("b2b_count", dones, 3);
      check("b2b_first", first, 9);
      check("b2b_last", last, 29);
    end
    repeat (12) @(negedge clk);
    check("b2b_stopped", busy, 0);

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
